fetch_stage: RTL

- Instruction fetch front end that drives the instruction port of the memory interface (inst_start/i_addr in, inst/inst_valid/inst_ready back).
- Generates sequential PCs and issues exactly one fetch at a time.
- Buffers returned {pc, inst} pairs in a small FIFO toward decode with a valid/ready handshake.
- Accepts a redirect (branch/jump) from execute that flushes the buffer and any fetch in flight.

---
 rtl/fetch_stage_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants.
// Entry layout, FSM encodings and reset PC default.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          ENTRY_W      = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(
    input logic [31:0] a
  );
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode.
// Flush clears pointers and count; flush beats push/pop.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ENTRY_W,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0) && !flush_i;
  assign do_push = push_i && !flush_i &&
                   ((count_q != DEPTH_C) || do_pop);

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; count gates its visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: one fetch in flight,
// {pc, inst} buffered toward decode, redirect flush.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        inst_start,
  input  logic        inst_ready,
  output logic [31:0] i_addr,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         start_q, start_d;
  logic         discard_q, discard_d;
  logic         push;
  logic         has_room;
  logic [CW-1:0] count;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  assign has_room   = count < DEPTH_C;
  assign push_entry = {addr_q, inst};

  // Fetch FSM state and request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= '0;
      start_q   <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      start_q   <= start_d;
      discard_q <= discard_d;
    end
  end

  // Next-state: issue, wait, capture; redirect wins on pc
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    start_d   = 1'b0;
    discard_d = discard_q;
    push      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!redirect_valid && inst_ready && has_room) begin
          addr_d  = pc_q;
          start_d = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = REQ;
        end
      end
      REQ: begin
        state_d = WAIT;
        if (redirect_valid) discard_d = 1'b1;
      end
      WAIT: begin
        if (inst_valid) begin
          push      = !discard_q && !redirect_valid;
          discard_d = 1'b0;
          state_d   = IDLE;
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) pc_d = align_pc(redirect_pc);
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (out_valid && out_ready),
    .data_o  (head),
    .count_o (count)
  );

  assign inst_start = start_q;
  assign i_addr     = addr_q;
  assign out_valid  = count != '0;
  assign out_pc     = head.pc;
  assign out_inst   = head.inst;

endmodule
